seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Output-side counterpart of the switch debouncer: drives a multiplexed common-anode seven-segment display.
//  Holds a NUM_DIGITS hex value and scans digits with a fixed dwell time and an inter-digit blanking gap.
//  New values are accepted via a load handshake, applied only at a frame boundary (no tearing).
//  Sits between the counter logic and the board display pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; digit 0 = least significant nibble
//  DWELL_CYCLES  25000  clocks each digit is lit (1 ms at 25 MHz); must be >= 1
//  BLANK_CYCLES  250    clocks all anodes off before each digit (ghost suppression); 0 = no gap
//  SEG_ACT_LOW   1      1: segment lit when o_Segment bit = 0
//  AN_ACT_LOW    1      1: digit enabled when o_Anode bit = 0
// PORTS
//  i_Clk          in   1              system clock
//  i_Rst_L        in   1              asynchronous active-low reset
//  i_Value        in   4*NUM_DIGITS   hex nibbles; [3:0] = digit 0
//  i_Load         in   1              load request; captures i_Value this cycle
//  i_Blank_Lz     in   1              leading-zero blanking enable
//  o_Load_Ack     out  1              1-cycle pulse: loaded value now owns display
//  o_Frame_Start  out  1              1-cycle pulse at every frame boundary
//  o_Segment      out  7              {g,f,e,d,c,b,a}
//  o_Anode        out  NUM_DIGITS     one-hot digit enable; bit k = digit k
// BEHAVIOUR
//  Reset (async assert, sync release): o_Segment/o_Anode all-off (per polarity params), acks 0,
//   display/staging regs 0, pending 0, blank-LZ reg 0, FSM = first cycle of digit-0 slot.
//  Slot k: BLANK for BLANK_CYCLES (anodes off, segs off), then DRIVE for DWELL_CYCLES (anode k on,
//   segs = decode(display nibble k)); k wraps NUM_DIGITS-1 -> 0. Frame = NUM_DIGITS*(BLANK+DWELL) clocks.
//  FSM states: BLANK, DRIVE; BLANK_CYCLES=0 -> BLANK never entered.
//  Counter width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); reload 0 on every state change.
//  Boundary = first cycle of digit-0 slot (includes first clock after reset release).
//  i_Load high: staging <= i_Value, pending <= 1. Several loads per frame: last wins.
//  At boundary edge: if pending or i_Load: display <= (i_Load ? i_Value : staging), pending <= 0,
//   o_Load_Ack = 1 next cycle. i_Blank_Lz sampled into blank-LZ reg at every boundary.
//  o_Frame_Start = 1 for the cycle after each boundary edge, regardless of load.
//  All outputs registered: o_Anode/o_Segment reflect state one clock after state change;
//   anode and segment change on the same edge (never a lit anode with stale segments).
//  Decode (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   A=77 b=7C C=39 d=5E E=79 F=71; inverted when SEG_ACT_LOW=1.
//  LZ blanking: digit k>0 blanked (segs off, anode off) if blank-LZ reg = 1 and nibbles k..NUM_DIGITS-1
//   all zero; digit 0 always shown (value 0 -> "0"). Slot timing unchanged by blanking.
//  Reset mid-frame: outputs off immediately; staged/pending load discarded.
// STRUCTURE
//  Package seg7_pkg: state enum {BLANK,DRIVE}, 16-entry segment pattern constant, SEG_OFF constant.
//  Sub-module seg7_hex_decode (4-bit nibble -> 7-bit active-high pattern, combinational).
//  Top: FSM + dwell counter, digit index, staging/display regs, LZ mask, output polarity regs.
// TESTING (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, active-low; frame = 24 clocks)
//  1 Reset, no load -> anodes 1111 for 2 clk, then 1110 4 clk with segs 7'h40 ("0"); o_Frame_Start every 24 clk.
//  2 i_Load=1 with 16'h12AF mid-frame -> display unchanged until boundary; o_Load_Ack 1 clk with
//    o_Frame_Start; next frame digits 0..3 show F,A,2,1 (active-low 0E,08,24,79).
//  3 Loads 16'h1111 then 16'h2222 same frame -> only 2222 displayed; exactly one o_Load_Ack.
//  4 i_Load=1 on boundary cycle with 16'h0005 -> shown from that frame's digit 0; ack next clk.
//  5 i_Blank_Lz=1, value 16'h0040 -> digits 0,1 lit ("0","4"); digits 2,3 anodes stay 1 (off).
//  6 Assert i_Rst_L mid-DRIVE of digit 2 -> o_Anode=1111, o_Segment=7F same cycle (async); after
//    release display 0, pending load lost, frame restarts at digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared scan states and hex segment patterns for the seven-segment driver
package seg7_pkg;

    typedef enum logic {BLANK, DRIVE} scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns, indexed by nibble value
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high seven-segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    always_comb pattern = SEG_PATTERNS[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment scanner with frame-aligned value loading
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 25000,
    parameter int BLANK_CYCLES = 250,
    parameter int SEG_ACT_LOW  = 1,
    parameter int AN_ACT_LOW   = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Load,
    input  logic                    i_Blank_Lz,
    output logic                    o_Load_Ack,
    output logic                    o_Frame_Start,
    output logic [6:0]              o_Segment,
    output logic [NUM_DIGITS-1:0]   o_Anode
);

    localparam int CNT_MAX = DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int VW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         DWELL_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]         BLANK_LAST  = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [DW-1:0]         LAST_DIGIT  = DW'(NUM_DIGITS - 1);
    localparam scan_state_t           FIRST_STATE = BLANK_CYCLES > 0 ? BLANK : DRIVE;
    localparam logic [6:0]            SEG_IDLE    = SEG_ACT_LOW != 0 ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE     = AN_ACT_LOW != 0 ? '1 : '0;

    scan_state_t           state;
    logic [CW-1:0]         cnt;
    logic [DW-1:0]         digit;
    logic [VW-1:0]         staging;
    logic [VW-1:0]         display;
    logic [VW-1:0]         disp_eff;
    logic                  pending;
    logic                  lz_reg;
    logic                  lz_eff;
    logic                  boundary;
    logic                  take;
    logic                  lz_hide;
    logic                  lit;
    logic [3:0]            nibble;
    logic [6:0]            pattern;
    logic [6:0]            seg_drive;
    logic [NUM_DIGITS-1:0] an_on;
    logic [NUM_DIGITS-1:0] an_drive;

    seg7_hex_decode u_decode (
        .nibble  (nibble),
        .pattern (pattern)
    );

    // A load landing on the boundary cycle is decoded directly, so the new
    // value is visible from this frame's digit 0 even when there is no blank gap.
    always_comb begin
        boundary  = state == FIRST_STATE && cnt == '0 && digit == '0;
        take      = boundary && (pending || i_Load);
        disp_eff  = take ? (i_Load ? i_Value : staging) : display;
        lz_eff    = boundary ? i_Blank_Lz : lz_reg;
        nibble    = disp_eff[{digit, 2'b00} +: 4];
        lz_hide   = lz_eff && digit != '0 && (disp_eff >> {digit, 2'b00}) == '0;
        lit       = state == DRIVE && !lz_hide;
        an_on     = NUM_DIGITS'(1) << digit;
        an_drive  = AN_ACT_LOW != 0 ? ~an_on : an_on;
        seg_drive = SEG_ACT_LOW != 0 ? ~pattern : pattern;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= FIRST_STATE;
            cnt           <= '0;
            digit         <= '0;
            staging       <= '0;
            display       <= '0;
            pending       <= 1'b0;
            lz_reg        <= 1'b0;
            o_Load_Ack    <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Segment     <= SEG_IDLE;
            o_Anode       <= AN_IDLE;
        end else begin
            if (state == BLANK) begin
                state <= cnt == BLANK_LAST ? DRIVE : BLANK;
                cnt   <= cnt == BLANK_LAST ? '0 : cnt + CW'(1);
            end else if (cnt == DWELL_LAST) begin
                state <= FIRST_STATE;
                cnt   <= '0;
                digit <= digit == LAST_DIGIT ? '0 : digit + DW'(1);
            end else begin
                cnt   <= cnt + CW'(1);
            end
            if (i_Load) staging <= i_Value;
            pending       <= boundary ? 1'b0 : (pending || i_Load);
            display       <= disp_eff;
            lz_reg        <= lz_eff;
            o_Load_Ack    <= take;
            o_Frame_Start <= boundary;
            o_Anode       <= lit ? an_drive : AN_IDLE;
            o_Segment     <= lit ? seg_drive : SEG_IDLE;
        end
    end

endmodule
